// File: rtl/fir_cascade_pkg.sv
// Shared definitions for the FIR cascade stages.
// Holds default widths, the accumulator width helper and the accumulator FSM states.
package fir_cascade_pkg;

    localparam int unsigned PROD_W_DEF     = 29;
    localparam int unsigned NTAPS_DEF      = 16;
    localparam int unsigned FRAC_SHIFT_DEF = 12;
    localparam int unsigned OUT_W_DEF      = 16;

    // Width that holds the sum of ntaps full-scale products without overflow
    function automatic int unsigned acc_width(input int unsigned prod_w,
                                              input int unsigned ntaps);
        return prod_w + $clog2(ntaps);
    endfunction

    typedef enum logic {
        ACCUM = 1'b0,
        ROUND = 1'b1
    } state_t;

endpackage

// File: rtl/fir_round_sat.sv
// Combinational round-half-up and saturate from the accumulator Q-format to the sample domain.
// Ports:
//   i_acc    : signed accumulator value
//   o_sample : rounded, saturated signed sample
//   o_sat    : high when o_sample was clamped
module fir_round_sat #(
    parameter int unsigned ACC_W      = 33,
    parameter int unsigned FRAC_SHIFT = 12,
    parameter int unsigned OUT_W      = 16
) (
    input  logic signed [ACC_W-1:0] i_acc,
    output logic signed [OUT_W-1:0] o_sample,
    output logic                    o_sat
);

    // One guard bit so adding the rounding constant can never wrap
    localparam int unsigned SW = ACC_W + 1;

    localparam logic signed [SW-1:0] HALF  = SW'(1) << (FRAC_SHIFT - 1);
    localparam logic signed [SW-1:0] MAX_V = (SW'(1) << (OUT_W - 1)) - SW'(1);
    localparam logic signed [SW-1:0] MIN_V = -MAX_V - SW'(1);

    logic signed [SW-1:0] w_ext;
    logic signed [SW-1:0] w_sum;
    logic signed [SW-1:0] w_shr;
    logic                 w_hi;
    logic                 w_lo;

    assign w_ext = {i_acc[ACC_W-1], i_acc};
    assign w_sum = w_ext + HALF;
    assign w_shr = w_sum >>> FRAC_SHIFT;
    assign w_hi  = (w_shr > MAX_V);
    assign w_lo  = (w_shr < MIN_V);

    always_comb begin
        o_sample = w_shr[OUT_W-1:0];
        if (w_hi) begin
            o_sample = MAX_V[OUT_W-1:0];
        end else if (w_lo) begin
            o_sample = MIN_V[OUT_W-1:0];
        end
    end

    assign o_sat = w_hi | w_lo;

endmodule

// File: rtl/fir_tap_accumulator.sv
// Accumulates NTAPS signed tap products per output sample, then rounds and saturates
// the sum into a registered valid/ready output stage.
// Ports:
//   ap_clk, ap_rst              : clock, asynchronous active-high reset
//   prod_tdata/tvalid/tlast/tready : product input stream (tlast is checked only)
//   out_tdata/tvalid/tready     : rounded sample output stream
//   sat_flag                    : sticky, any output saturated
//   frame_err                   : sticky, tlast disagreed with the tap count
module fir_tap_accumulator
    import fir_cascade_pkg::*;
#(
    parameter int unsigned PROD_W     = PROD_W_DEF,
    parameter int unsigned NTAPS      = NTAPS_DEF,
    parameter int unsigned ACC_W      = acc_width(PROD_W, NTAPS),
    parameter int unsigned FRAC_SHIFT = FRAC_SHIFT_DEF,
    parameter int unsigned OUT_W      = OUT_W_DEF
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst,
    input  logic signed [PROD_W-1:0] prod_tdata,
    input  logic                     prod_tvalid,
    input  logic                     prod_tlast,
    output logic                     prod_tready,
    output logic signed [OUT_W-1:0]  out_tdata,
    output logic                     out_tvalid,
    input  logic                     out_tready,
    output logic                     sat_flag,
    output logic                     frame_err
);

    localparam int unsigned       CNT_W    = $clog2(NTAPS);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NTAPS - 1);

    state_t                    r_state;
    logic [CNT_W-1:0]          r_tap_cnt;
    logic signed [ACC_W-1:0]   r_acc;
    logic signed [OUT_W-1:0]   r_out_tdata;
    logic                      r_out_tvalid;
    logic                      r_prod_tready;
    logic                      r_sat_flag;
    logic                      r_frame_err;

    state_t                    w_state_nxt;
    logic [CNT_W-1:0]          w_cnt_nxt;
    logic signed [ACC_W-1:0]   w_acc_nxt;
    logic signed [OUT_W-1:0]   w_out_data_nxt;
    logic                      w_out_valid_nxt;
    logic                      w_ready_nxt;
    logic                      w_sat_nxt;
    logic                      w_ferr_nxt;

    logic                      w_accept;
    logic                      w_last_tap;
    logic signed [ACC_W-1:0]   w_prod_ext;
    logic signed [OUT_W-1:0]   w_round;
    logic                      w_round_sat;

    fir_round_sat #(
        .ACC_W      (ACC_W),
        .FRAC_SHIFT (FRAC_SHIFT),
        .OUT_W      (OUT_W)
    ) u_round_sat (
        .i_acc    (r_acc),
        .o_sample (w_round),
        .o_sat    (w_round_sat)
    );

    // Ready is only ever high in ACCUM, so accept implies ACCUM
    assign w_accept   = prod_tvalid & r_prod_tready;
    assign w_last_tap = (r_tap_cnt == LAST_CNT);
    assign w_prod_ext = {{(ACC_W - PROD_W){prod_tdata[PROD_W-1]}}, prod_tdata};

    // Next-state and datapath update
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_tap_cnt;
        w_acc_nxt       = r_acc;
        w_out_data_nxt  = r_out_tdata;
        w_out_valid_nxt = r_out_tvalid;
        w_sat_nxt       = r_sat_flag;
        w_ferr_nxt      = r_frame_err;

        if (r_out_tvalid && out_tready) begin
            w_out_valid_nxt = 1'b0;
        end

        case (r_state)
            ACCUM: begin
                if (w_accept) begin
                    w_acc_nxt = (r_tap_cnt == '0) ? w_prod_ext : r_acc + w_prod_ext;
                    if (prod_tlast != w_last_tap) begin
                        w_ferr_nxt = 1'b1;
                    end
                    if (w_last_tap) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ROUND;
                    end else begin
                        w_cnt_nxt = r_tap_cnt + CNT_W'(1);
                    end
                end
            end
            ROUND: begin
                // Entered only with the output register empty
                w_out_data_nxt  = w_round;
                w_out_valid_nxt = 1'b1;
                if (w_round_sat) begin
                    w_sat_nxt = 1'b1;
                end
                w_state_nxt = ACCUM;
            end
            default: begin
                w_state_nxt = ACCUM;
            end
        endcase

        // Registered ready: the last tap waits until the output register is free
        w_ready_nxt = (w_state_nxt == ACCUM) &&
                      !((w_cnt_nxt == LAST_CNT) && w_out_valid_nxt);
    end

    // State and datapath registers
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_state       <= ACCUM;
            r_tap_cnt     <= '0;
            r_acc         <= '0;
            r_out_tdata   <= '0;
            r_out_tvalid  <= 1'b0;
            r_prod_tready <= 1'b1;
            r_sat_flag    <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_tap_cnt     <= w_cnt_nxt;
            r_acc         <= w_acc_nxt;
            r_out_tdata   <= w_out_data_nxt;
            r_out_tvalid  <= w_out_valid_nxt;
            r_prod_tready <= w_ready_nxt;
            r_sat_flag    <= w_sat_nxt;
            r_frame_err   <= w_ferr_nxt;
        end
    end

    assign prod_tready = r_prod_tready;
    assign out_tdata   = r_out_tdata;
    assign out_tvalid  = r_out_tvalid;
    assign sat_flag    = r_sat_flag;
    assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_fir_tap_accumulator.sv
// Self-checking bench for fir_tap_accumulator: directed cases plus random frames
// compared against an arithmetic reference model.
module tb_fir_tap_accumulator;

    localparam int NT = 16;

    logic               ap_clk;
    logic               ap_rst;
    logic [28:0]        prod_tdata;
    logic               prod_tvalid;
    logic               prod_tlast;
    logic               prod_tready;
    logic [15:0]        out_tdata;
    logic               out_tvalid;
    logic               out_tready;
    logic               sat_flag;
    logic               frame_err;

    int     vectors;
    int     miscompares;
    longint frame [NT];
    logic   exp_sat;

    fir_tap_accumulator dut (
        .ap_clk      (ap_clk),
        .ap_rst      (ap_rst),
        .prod_tdata  (prod_tdata),
        .prod_tvalid (prod_tvalid),
        .prod_tlast  (prod_tlast),
        .prod_tready (prod_tready),
        .out_tdata   (out_tdata),
        .out_tvalid  (out_tvalid),
        .out_tready  (out_tready),
        .sat_flag    (sat_flag),
        .frame_err   (frame_err)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp_v);
        vectors++;
        assert (obs === exp_v)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    // Floor division, so the model does not rely on shift semantics
    function automatic longint floor_div(input longint a, input longint d);
        longint q;
        q = a / d;
        if ((a % d != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    // Reference: sum all taps, round half up at 2^-12, clamp to 16-bit range
    task automatic model(output longint y, output logic s);
        longint sum;
        longint q;
        sum = 0;
        for (int i = 0; i < NT; i++) sum += frame[i];
        q = floor_div(sum + 2048, 4096);
        s = 1'b0;
        y = q;
        if (q > 32767) begin
            y = 32767;
            s = 1'b1;
        end else if (q < -32768) begin
            y = -32768;
            s = 1'b1;
        end
    endtask

    // Present one beat and hold until it is accepted; returns at edge+1 after acceptance
    task automatic send(input longint d, input logic l);
        int n;
        prod_tdata  = 29'(d);
        prod_tlast  = l;
        prod_tvalid = 1'b1;
        n = 0;
        while (!prod_tready && n < 64) begin
            tick();
            n++;
        end
        if (n >= 64) chk("tready_timeout", 64'(prod_tready), 64'd1);
        tick();
        prod_tvalid = 1'b0;
        prod_tlast  = 1'b0;
    endtask

    task automatic send_frame(input int last_pos, input bit gaps);
        for (int i = 0; i < NT; i++) begin
            if (gaps) repeat ($urandom_range(1, 0)) tick();
            send(frame[i], 1'(i == last_pos));
        end
    endtask

    // Wait for an output, compare it, and let it drain if out_tready is high
    task automatic wait_out(input string tag, input longint exp_y);
        int n;
        n = 0;
        while (!out_tvalid && n < 64) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, 64'(out_tvalid), 64'd1);
        chk(tag, 64'($signed(out_tdata)), 64'(exp_y));
        if (out_tready) tick();
    endtask

    task automatic fill(input longint v);
        for (int i = 0; i < NT; i++) frame[i] = v;
    endtask

    task automatic pulse_reset();
        ap_rst = 1'b1;
        #1;
        chk("rst_out_tvalid", 64'(out_tvalid), 64'd0);
        chk("rst_prod_tready", 64'(prod_tready), 64'd1);
        #2;
        ap_rst = 1'b0;
        exp_sat = 1'b0;
        tick();
    endtask

    initial begin
        longint y;
        logic   s;
        longint ya;
        int     k;

        vectors     = 0;
        miscompares = 0;
        exp_sat     = 1'b0;
        ap_rst      = 1'b1;
        prod_tdata  = '0;
        prod_tvalid = 1'b0;
        prod_tlast  = 1'b0;
        out_tready  = 1'b1;

        // Reset state
        repeat (2) tick();
        chk("reset_out_tdata", 64'($signed(out_tdata)), 64'd0);
        chk("reset_out_tvalid", 64'(out_tvalid), 64'd0);
        chk("reset_sat_flag", 64'(sat_flag), 64'd0);
        chk("reset_frame_err", 64'(frame_err), 64'd0);
        chk("reset_prod_tready", 64'(prod_tready), 64'd1);
        ap_rst = 1'b0;
        tick();

        // Unity sum with exact latency
        fill(4096);
        send_frame(NT - 1, 1'b0);
        chk("lat_round_cycle", 64'(out_tvalid), 64'd0);
        chk("lat_round_ready", 64'(prod_tready), 64'd0);
        tick();
        chk("lat_valid", 64'(out_tvalid), 64'd1);
        chk("unity_data", 64'($signed(out_tdata)), 64'd16);
        tick();
        chk("unity_drained", 64'(out_tvalid), 64'd0);
        chk("unity_sat", 64'(sat_flag), 64'd0);
        chk("unity_ferr", 64'(frame_err), 64'd0);

        // Rounding boundaries
        fill(0); frame[0] = 2048;
        send_frame(NT - 1, 1'b0);
        wait_out("round_p2048", 1);
        fill(0); frame[0] = -2048;
        send_frame(NT - 1, 1'b0);
        wait_out("round_m2048", 0);
        fill(0); frame[0] = -2049;
        send_frame(NT - 1, 1'b0);
        wait_out("round_m2049", -1);
        chk("round_sat", 64'(sat_flag), 64'd0);

        // Saturation, both rails
        fill(134217728);
        send_frame(NT - 1, 1'b0);
        wait_out("sat_pos", 32767);
        chk("sat_pos_flag", 64'(sat_flag), 64'd1);
        pulse_reset();
        chk("sat_cleared", 64'(sat_flag), 64'd0);
        fill(-268435456);
        send_frame(NT - 1, 1'b0);
        wait_out("sat_neg", -32768);
        chk("sat_neg_flag", 64'(sat_flag), 64'd1);
        pulse_reset();

        // Backpressure: first result held, second frame stalls only on its last tap
        out_tready = 1'b0;
        for (int i = 0; i < NT; i++) frame[i] = longint'($urandom_range(2000000, 0)) - 1000000;
        model(ya, s);
        exp_sat = exp_sat | s;
        send_frame(NT - 1, 1'b0);
        wait_out("bp_first", ya);
        for (int i = 0; i < NT; i++) frame[i] = longint'($urandom_range(2000000, 0)) - 1000000;
        model(y, s);
        for (int i = 0; i < NT - 1; i++) begin
            chk("bp_ready_early", 64'(prod_tready), 64'd1);
            send(frame[i], 1'b0);
        end
        chk("bp_stall", 64'(prod_tready), 64'd0);
        chk("bp_hold_valid", 64'(out_tvalid), 64'd1);
        repeat (3) tick();
        chk("bp_stall_held", 64'(prod_tready), 64'd0);
        chk("bp_hold_data", 64'($signed(out_tdata)), 64'(ya));
        out_tready = 1'b1;
        tick();
        chk("bp_released_valid", 64'(out_tvalid), 64'd0);
        chk("bp_released_ready", 64'(prod_tready), 64'd1);
        send(frame[NT - 1], 1'b1);
        exp_sat = exp_sat | s;
        wait_out("bp_second", y);
        chk("bp_sat", 64'(sat_flag), 64'(exp_sat));

        // Framing error: early tlast is flagged but the tap count still rules
        for (int i = 0; i < NT; i++) frame[i] = longint'($urandom_range(200000, 0)) - 100000;
        model(y, s);
        exp_sat = exp_sat | s;
        for (int i = 0; i < NT; i++) begin
            send(frame[i], 1'(i == 9));
            if (i == 8) chk("ferr_before", 64'(frame_err), 64'd0);
            if (i == 9) chk("ferr_set", 64'(frame_err), 64'd1);
        end
        wait_out("ferr_output", y);
        repeat (2) tick();
        chk("ferr_sticky", 64'(frame_err), 64'd1);
        pulse_reset();
        chk("ferr_cleared", 64'(frame_err), 64'd0);

        // Reset mid-frame with a pending output
        out_tready = 1'b0;
        fill(4096);
        send_frame(NT - 1, 1'b0);
        wait_out("pre_rst_out", 16);
        for (int i = 0; i < 7; i++) send(4096, 1'b0);
        pulse_reset();
        chk("post_rst_data", 64'($signed(out_tdata)), 64'd0);
        out_tready = 1'b1;
        fill(4096);
        send_frame(NT - 1, 1'b0);
        wait_out("post_rst_frame", 16);
        chk("post_rst_ferr", 64'(frame_err), 64'd0);

        // Random frames with random input gaps and magnitudes
        for (int f = 0; f < 24; f++) begin
            k = int'($urandom_range(29, 8));
            for (int i = 0; i < NT; i++)
                frame[i] = longint'($urandom_range((2 ** k) - 1, 0)) - (longint'(1) << (k - 1));
            model(y, s);
            exp_sat = exp_sat | s;
            send_frame(NT - 1, 1'b1);
            wait_out("rand_frame", y);
            chk("rand_sat", 64'(sat_flag), 64'(exp_sat));
        end
        chk("rand_ferr", 64'(frame_err), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
